// File: rtl/instruction_encoder.sv
// MIPS instruction encoder and program loader: packs decoded instruction fields
// into 32-bit words and writes them to consecutive instruction-memory addresses.
module instruction_encoder #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_kind,
   input  logic [4:0]            in_rs,
   input  logic [4:0]            in_rt,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_shamt,
   input  logic [5:0]            in_funct,
   input  logic [15:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state;
   state_t                state_next;
   logic                  accept;
   logic                  legal;
   logic [31:0]           encoded;
   logic [ADDR_WIDTH:0]   count_inc;

   assign in_ready  = (state == LOAD) && !start;
   assign accept    = in_valid && in_ready;
   assign legal     = (in_kind <= 3'd5);
   assign count_inc = count + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign full      = (state == FULL);

   // Kinds 6/7 encode to zero but are never written.
   always_comb begin
      encoded = 32'h0;
      case (in_kind)
         3'd0:    encoded = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
         3'd1:    encoded = {6'h08, in_rs, in_rt, in_imm};
         3'd2:    encoded = {6'h0d, in_rs, in_rt, in_imm};
         3'd3:    encoded = {6'h0c, in_rs, in_rt, in_imm};
         3'd4:    encoded = {6'h0f, 5'd0, in_rt, in_imm};
         3'd5:    encoded = {6'h23, in_rs, in_rt, in_imm};
         default: encoded = 32'h0;
      endcase
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = LOAD;
      end else if (accept && legal && (count_inc == CAPACITY)) begin
         state_next = FULL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // start never coincides with an acceptance, so the clear cannot race a write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         mem_we <= accept && legal;
         if (start) begin
            count <= '0;
            err   <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               mem_addr  <= count[ADDR_WIDTH-1:0];
               mem_wdata <= encoded;
               count     <= count_inc;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a default-size instance plus a
// four-word instance for the full/stall behaviour, both on shared inputs.
module tb_instruction_encoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [2:0]  in_kind;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;

   logic        in_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [6:0]  count;
   logic        full;
   logic        err;

   logic        in_ready_s;
   logic        mem_we_s;
   logic [1:0]  mem_addr_s;
   logic [31:0] mem_wdata_s;
   logic [2:0]  count_s;
   logic        full_s;
   logic        err_s;

   int checks = 0;
   int errors = 0;

   instruction_encoder #(.ADDR_WIDTH(6)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .err(err)
   );

   instruction_encoder #(.ADDR_WIDTH(2)) dut_small (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(in_ready_s), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
      .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
      .count(count_s), .full(full_s), .err(err_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                                input logic [15:0] imm);
      in_kind  = kind;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_shamt = shamt;
      in_funct = funct;
      in_imm   = imm;
      in_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [31:0] b2b_expected [4];

   initial begin
      b2b_expected[0] = 32'h012A4020;
      b2b_expected[1] = 32'h8FA80004;
      b2b_expected[2] = 32'h3C011001;
      b2b_expected[3] = 32'h34210024;

      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
      in_valid = 1'b0;
      step();
      step();
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      reset = 1'b1;
      step();
      checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

      // Single ADDI.
      start = 1'b1;
      #1;
      checkOutput("start_blocks_ready", 32'(in_ready), 32'd0);
      step();
      start = 1'b0;
      #1;
      checkOutput("load_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005);
      step();
      in_valid = 1'b0;
      checkOutput("addi_we", 32'(mem_we), 32'd1);
      checkOutput("addi_addr", 32'(mem_addr), 32'd0);
      checkOutput("addi_wdata", mem_wdata, 32'h20080005);
      checkOutput("addi_count", 32'(count), 32'd1);
      step();
      checkOutput("addi_we_drop", 32'(mem_we), 32'd0);
      checkOutput("addi_wdata_hold", mem_wdata, 32'h20080005);

      // Back-to-back beats.
      pulseStart();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: applyStimulus(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0000);
            1: applyStimulus(3'd5, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004);
            2: applyStimulus(3'd4, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001);
            default: applyStimulus(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0024);
         endcase
         step();
         checkOutput($sformatf("b2b_we_%0d", k), 32'(mem_we), 32'd1);
         checkOutput($sformatf("b2b_addr_%0d", k), 32'(mem_addr), 32'(k));
         checkOutput($sformatf("b2b_wdata_%0d", k), mem_wdata, b2b_expected[k]);
      end
      in_valid = 1'b0;
      checkOutput("b2b_count", 32'(count), 32'd4);

      // Illegal kind between two ADDI beats.
      pulseStart();
      applyStimulus(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003);
      step();
      checkOutput("ill_a_we", 32'(mem_we), 32'd1);
      checkOutput("ill_a_wdata", mem_wdata, 32'h20220003);
      applyStimulus(3'd6, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234);
      step();
      checkOutput("ill_no_we", 32'(mem_we), 32'd0);
      checkOutput("ill_err", 32'(err), 32'd1);
      checkOutput("ill_count", 32'(count), 32'd1);
      checkOutput("ill_wdata_hold", mem_wdata, 32'h20220003);
      applyStimulus(3'd1, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'hFFFF);
      step();
      in_valid = 1'b0;
      checkOutput("ill_b_we", 32'(mem_we), 32'd1);
      checkOutput("ill_b_addr", 32'(mem_addr), 32'd1);
      checkOutput("ill_b_wdata", mem_wdata, 32'h2003FFFF);
      step();
      checkOutput("ill_err_sticky", 32'(err), 32'd1);
      checkOutput("ill_count_final", 32'(count), 32'd2);
      pulseStart();
      checkOutput("start_clears_err", 32'(err), 32'd0);
      checkOutput("start_clears_count", 32'(count), 32'd0);

      // Four-word instance: fill, stall, restart.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'd3, 5'd2, 5'd4, 5'd0, 5'd0, 6'd0, 16'(k));
         step();
         checkOutput($sformatf("fill_we_%0d", k), 32'(mem_we_s), 32'd1);
         checkOutput($sformatf("fill_addr_%0d", k), 32'(mem_addr_s), 32'(k));
         checkOutput($sformatf("fill_wdata_%0d", k), mem_wdata_s, 32'h30440000 + 32'(k));
      end
      checkOutput("fill_full", 32'(full_s), 32'd1);
      checkOutput("fill_ready", 32'(in_ready_s), 32'd0);
      checkOutput("fill_count", 32'(count_s), 32'd4);
      applyStimulus(3'd3, 5'd2, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0004);
      step();
      checkOutput("stall_we_0", 32'(mem_we_s), 32'd0);
      step();
      checkOutput("stall_we_1", 32'(mem_we_s), 32'd0);
      checkOutput("stall_full", 32'(full_s), 32'd1);
      start = 1'b1;
      #1;
      checkOutput("restart_ready_blocked", 32'(in_ready_s), 32'd0);
      step();
      start = 1'b0;
      #1;
      checkOutput("restart_no_we", 32'(mem_we_s), 32'd0);
      checkOutput("restart_full_clear", 32'(full_s), 32'd0);
      checkOutput("restart_ready", 32'(in_ready_s), 32'd1);
      step();
      in_valid = 1'b0;
      checkOutput("restart_we", 32'(mem_we_s), 32'd1);
      checkOutput("restart_addr", 32'(mem_addr_s), 32'd0);
      checkOutput("restart_wdata", mem_wdata_s, 32'h30440004);

      // Stall gap between two beats.
      pulseStart();
      applyStimulus(3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF);
      step();
      in_valid = 1'b0;
      checkOutput("gap_a_we", 32'(mem_we), 32'd1);
      checkOutput("gap_a_addr", 32'(mem_addr), 32'd0);
      checkOutput("gap_a_wdata", mem_wdata, 32'h346400FF);
      step();
      checkOutput("gap_no_we", 32'(mem_we), 32'd0);
      applyStimulus(3'd4, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'hABCD);
      step();
      in_valid = 1'b0;
      checkOutput("gap_b_we", 32'(mem_we), 32'd1);
      checkOutput("gap_b_addr", 32'(mem_addr), 32'd1);
      checkOutput("gap_b_wdata", mem_wdata, 32'h3C05ABCD);
      step();
      checkOutput("gap_count", 32'(count), 32'd2);
      checkOutput("gap_we_end", 32'(mem_we), 32'd0);

      // Asynchronous reset while a write is presented.
      applyStimulus(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001);
      step();
      in_valid = 1'b0;
      checkOutput("arst_pre_we", 32'(mem_we), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("arst_we", 32'(mem_we), 32'd0);
      checkOutput("arst_addr", 32'(mem_addr), 32'd0);
      checkOutput("arst_wdata", mem_wdata, 32'd0);
      checkOutput("arst_count", 32'(count), 32'd0);
      checkOutput("arst_err", 32'(err), 32'd0);
      checkOutput("arst_full", 32'(full), 32'd0);
      checkOutput("arst_ready", 32'(in_ready), 32'd0);
      step();
      reset = 1'b1;
      applyStimulus(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0002);
      #1;
      checkOutput("post_rst_ready", 32'(in_ready), 32'd0);
      step();
      checkOutput("post_rst_no_we", 32'(mem_we), 32'd0);
      checkOutput("post_rst_count", 32'(count), 32'd0);
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential MIPS instruction encoder and program loader, the counterpart of the opcode-to-control decoder. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words. It writes the words one per cycle into consecutive instruction-memory locations. It sits between a test/boot source and the program memory, so programs are generated from the same instruction set the control unit decodes (R-type, ADDI, ORI, ANDI, LUI, LW).

## Interface
- ADDR_WIDTH, 6, word-address width of the target instruction memory; capacity 2^ADDR_WIDTH words
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; clears count and err and enters LOAD
- in_valid  input  1  source has an instruction beat
- in_ready  output  1  encoder accepts a beat this cycle
- in_kind  input  3  0=R-type, 1=ADDI, 2=ORI, 3=ANDI, 4=LUI, 5=LW, 6/7=illegal
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields
- in_funct  input  6  R-type function field
- in_imm  input  16  I-type immediate
- mem_we  output  1  one-cycle write strobe to instruction memory
- mem_addr  output  ADDR_WIDTH  word address of the write
- mem_wdata  output  32  encoded instruction
- count  output  ADDR_WIDTH+1  words written since the last start
- full  output  1  high in state FULL
- err  output  1  sticky; an illegal in_kind was accepted

## Operation
- States:
  - IDLE (after reset): in_ready=0.
  - LOAD: accepts beats.
  - FULL: in_ready=0; all 2^ADDR_WIDTH words written.
- start=1 in any state: at the next edge count←0, err←0, state←LOAD. The write of a beat accepted earlier still completes.
- in_ready = (state==LOAD) && !start, combinational.
- Acceptance is in_valid && in_ready at a rising edge.
- Encoding, registered at acceptance:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}
  - ADDI: {6'h08, rs, rt, imm}
  - ORI: {6'h0d, rs, rt, imm}
  - ANDI: {6'h0c, rs, rt, imm}
  - LUI: {6'h0f, 5'd0, rt, imm}; the rs input is ignored.
  - LW: {6'h23, rs, rt, imm}
  - Fields unused by a format are ignored.
- Legal accepted beat:
  - mem_addr←count[ADDR_WIDTH-1:0], mem_wdata←encoding, mem_we←1 for the next cycle.
  - count←count+1.
  - If the new count equals 2^ADDR_WIDTH, state←FULL.
- Illegal accepted beat (kind 6/7): the handshake completes, err←1, no write, count unchanged.
- mem_we is 0 in every cycle not immediately following a legal acceptance.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- No wrap-around: a write to address 0 after address 2^ADDR_WIDTH-1 happens only through start.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0.
- Reset assertion takes effect immediately, mid-operation included. A pending mem_we drops asynchronously and no further write occurs.
- Latency: beat accepted at edge N → mem_we/mem_addr/mem_wdata valid in cycle N to N+1, sampled by memory at edge N+1.
- Throughput: one beat and one write per cycle, back-to-back with no bubbles.
- Last word accepted at edge N:
  - full=1 and in_ready=0 from edge N.
  - The last write is still presented in cycle N to N+1.
- start coincident with in_valid:
  - The beat is not accepted (in_ready=0 that cycle).
  - The source must hold the beat, per the valid/ready rule.
- The source must keep in_valid and all fields stable until accepted.

## Test plan
- Reset, start, then ADDI rs=0 rt=8 imm=0x0005 → one cycle later mem_we=1, mem_addr=0, mem_wdata=0x20080005; count=1.
- Back-to-back without gaps:
  - Beats: R-type rs=9 rt=10 rd=8 shamt=0 funct=0x20; LW rs=29 rt=8 imm=4; LUI rs=7 rt=1 imm=0x1001; ORI rs=1 rt=1 imm=0x0024.
  - Expected writes on consecutive cycles: 0x012A4020@0, 0x8FA80004@1, 0x3C011001@2, 0x34210024@3.
- Illegal kind 6 between two ADDI beats → err=1 persists, only two writes at addresses 0 and 1, count=2. Then start → err=0, count=0.
- ADDR_WIDTH=2, 5 beats offered continuously:
  - First 4 written to addresses 0 to 3.
  - full=1 and in_ready=0 after the 4th acceptance; the 5th beat is stalled.
  - start → 5th beat written to address 0.
- Stalls: in_valid toggled 1,0,1 → exactly two writes, addresses 0 and 1, with no write in the gap cycle.
- Reset driven low in the cycle mem_we=1 → mem_we goes 0 immediately, all outputs at reset values, in_ready=0 until start.
